// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, line idle level and parity modes.
// The future receiver is expected to import the same package.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_tx_tick.sv
// Asynchronous-frame transmitter paced by an external one-cycle baud tick.
// Each line bit is held from one tick to the next; the output is registered.
module uart_tx_tick
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              tx_busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              par_q, par_d;
  logic              line_q, line_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      line_q     <= LINE_IDLE;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      line_q     <= line_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    line_d     = line_q;
    unique case (state_q)
      ST_IDLE: begin
        line_d = LINE_IDLE;
        // Ticks here are ignored, so acceptance always waits for the next full tick.
        if (tx_valid) begin
          shift_d = tx_data;
          par_d   = (^tx_data) ^ PAR_MODE;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: if (baud_tick) begin
        state_d = ST_START;
        line_d  = 1'b0;
      end
      ST_START: if (baud_tick) begin
        state_d   = ST_DATA;
        line_d    = shift_q[0];
        bit_cnt_d = '0;
      end
      ST_DATA: if (baud_tick) begin
        if (bit_cnt_q == LAST_BIT) begin
          stop_cnt_d = 1'b0;
          if (PARITY_EN != 0) begin
            state_d = ST_PARITY;
            line_d  = par_q;
          end else begin
            state_d = ST_STOP;
            line_d  = LINE_IDLE;
          end
        end else begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          line_d    = shift_q[1];
        end
      end
      ST_PARITY: if (baud_tick) begin
        state_d    = ST_STOP;
        line_d     = LINE_IDLE;
        stop_cnt_d = 1'b0;
      end
      ST_STOP: if (baud_tick) begin
        if (stop_cnt_q == 1'(STOP_BITS - 1)) state_d = ST_IDLE;
        else                                 stop_cnt_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx_line  = line_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Three transmitter configurations (8N1, 8E1, 7O2) driven from a divide-by-4 tick,
// each frame checked cycle by cycle against a bit list built from the frame format.
module tb_uart_tx_tick;

  localparam int DIV = 4;
  localparam int DW[3] = '{8, 8, 7};
  localparam int PE[3] = '{0, 1, 1};
  localparam int PO[3] = '{0, 0, 1};
  localparam int SB[3] = '{1, 1, 2};

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       baud_tick;
  logic [7:0] data;
  logic [2:0] vld, rdy, line, busy;
  int         dcnt = 0;
  int         vectors = 0;
  int         errs = 0;
  bit         exp_q[$];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) dcnt <= (dcnt == DIV - 1) ? 0 : dcnt + 1;
  assign baud_tick = (dcnt == DIV - 1);

  uart_tx_tick #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .baud_tick(baud_tick), .tx_data(data),
    .tx_valid(vld[0]), .tx_ready(rdy[0]), .tx_line(line[0]), .tx_busy(busy[0]));
  uart_tx_tick #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .baud_tick(baud_tick), .tx_data(data),
    .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx_line(line[1]), .tx_busy(busy[1]));
  uart_tx_tick #(.DATA_W(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .baud_tick(baud_tick), .tx_data(data[6:0]),
    .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx_line(line[2]), .tx_busy(busy[2]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Line levels of one frame in transmission order.
  task automatic build(input int idx, input logic [7:0] d);
    bit p;
    exp_q.delete();
    exp_q.push_back(1'b0);
    p = PO[idx][0];
    for (int i = 0; i < DW[idx]; i++) begin
      exp_q.push_back(d[i]);
      p ^= d[i];
    end
    if (PE[idx] != 0) exp_q.push_back(p);
    for (int i = 0; i < SB[idx]; i++) exp_q.push_back(1'b1);
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      for (int k = 0; k < 3; k++) begin
        chk("idle_line", line[k], 1'b1);
        chk("idle_busy", busy[k], 1'b0);
        chk("idle_rdy", rdy[k], 1'b1);
      end
    end
  endtask

  // Entered just after a negedge with the target idle; returns just after a negedge.
  task automatic send(input int idx, input logic [7:0] d, input bit hold, input logic [7:0] nxt);
    bit got;
    data = d;
    vld[idx] = 1'b1;
    chk("acc_rdy", rdy[idx], 1'b1);
    build(idx, d);
    @(posedge sys_clk);
    @(negedge sys_clk);
    if (hold) data = nxt;
    else begin vld[idx] = 1'b0; data = 8'($urandom); end
    got = 1'b0;
    for (int i = 0; i < DIV; i++) begin
      if (i > 0) @(negedge sys_clk);
      chk("sync_line", line[idx], 1'b1);
      chk("sync_busy", busy[idx], 1'b1);
      chk("sync_rdy", rdy[idx], 1'b0);
      if (baud_tick) begin got = 1'b1; break; end
    end
    if (!got) chk("sync_timeout", 1'b0, 1'b1);
    foreach (exp_q[b]) begin
      for (int c = 0; c < DIV; c++) begin
        @(negedge sys_clk);
        if (!hold) data = 8'($urandom);
        chk($sformatf("bit%0d_line", b), line[idx], exp_q[b]);
        chk("frame_busy", busy[idx], 1'b1);
        chk("frame_rdy", rdy[idx], 1'b0);
      end
    end
    @(negedge sys_clk);
    chk("done_rdy", rdy[idx], 1'b1);
    chk("done_busy", busy[idx], 1'b0);
    chk("done_line", line[idx], 1'b1);
  endtask

  initial begin
    bit got;
    sys_rst_n = 1'b0;
    vld = '0;
    data = '0;
    repeat (3) @(negedge sys_clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_line", line[k], 1'b1);
      chk("rst_busy", busy[k], 1'b0);
      chk("rst_rdy", rdy[k], 1'b1);
    end
    sys_rst_n = 1'b1;
    idle_chk(2 * DIV);

    // Directed frames from the test plan.
    send(0, 8'hA5, 1'b0, 8'h00);
    send(1, 8'h07, 1'b0, 8'h00);
    send(2, 8'h07, 1'b0, 8'h00);
    send(2, 8'h00, 1'b0, 8'h00);
    send(0, 8'h11, 1'b1, 8'h22);
    send(0, 8'h22, 1'b0, 8'h00);

    // Accept in the same cycle as a tick: that tick must not start the frame.
    got = 1'b0;
    for (int i = 0; i < DIV && !got; i++) begin
      if (baud_tick) got = 1'b1;
      else @(negedge sys_clk);
    end
    chk("align_timeout", got, 1'b1);
    send(1, 8'h5A, 1'b0, 8'h00);

    // Reset in the middle of data bit 3.
    data = 8'h00;
    vld[0] = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    vld[0] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < DIV && !got; i++) begin
      if (baud_tick) got = 1'b1;
      else @(negedge sys_clk);
    end
    chk("rst_sync_timeout", got, 1'b1);
    repeat (4 * DIV + 2) @(negedge sys_clk);
    chk("pre_rst_line", line[0], 1'b0);
    sys_rst_n = 1'b0;
    vld[0] = 1'b1;
    #1;
    chk("mid_rst_line", line[0], 1'b1);
    chk("mid_rst_busy", busy[0], 1'b0);
    chk("mid_rst_rdy", rdy[0], 1'b1);
    repeat (2) @(negedge sys_clk);
    vld[0] = 1'b0;
    sys_rst_n = 1'b1;
    idle_chk(2 * DIV);
    send(0, 8'h3C, 1'b0, 8'h00);

    // Random words, targets and idle gaps (gaps shift alignment against the tick).
    for (int n = 0; n < 12; n++) begin
      int idx;
      idx = int'($urandom_range(0, 2));
      idle_chk(int'($urandom_range(0, 2 * DIV)));
      send(idx, 8'($urandom), 1'b0, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
